// File: rtl/keypad_pkg.sv
// Shared types and key decode for the keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_e;

   localparam logic [3:0] KEY_STOP = 4'hE;
   localparam logic [3:0] KEY_RUN  = 4'hF;

   // Map a (row, col) position to the hex value printed on the key.
   function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'h0;
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         4'hF: code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_digit_scan_sync.sv
// Two-flop synchronizer; resets to all ones so idle pulled-up inputs read as released.
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // Next-state of the two synchronizer stages.
   always_comb begin
      meta_d = din;
      sync_d = meta_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q;

endmodule

// File: rtl/keypad_digit_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce and key decode
// into digit/load/en for the stepper driver.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SCAN     | rotate columns, look for exactly one low row
// ST_DEBOUNCE | column frozen, count consecutive matches of the candidate
// ST_HELD     | key acted on, column frozen, count consecutive all-high samples
module keypad_digit_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1024,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] digit,
   output logic       load,
   output logic       en
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

   logic [3:0]    rows_sync;
   state_e        state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [CW-1:0] match_q, match_d;
   logic [CW-1:0] rel_q, rel_d;
   logic [1:0]    cand_row_q, cand_row_d;
   logic [3:0]    digit_q, digit_d;
   logic          load_q, load_d;
   logic          en_q, en_d;

   logic [3:0]    row_low;
   logic          one_low;
   logic [1:0]    row_idx;
   logic          sample;
   logic          cand_match;
   logic [CW-1:0] match_inc;
   logic [CW-1:0] rel_inc;
   logic [3:0]    code;

   sync_2ff #(.WIDTH(4)) u_rows_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (rows),
      .dout    (rows_sync)
   );

   // Classify the synced rows: which single row (if any) is pulled low.
   always_comb begin
      row_low = ~rows_sync;
      one_low = 1'b0;
      row_idx = 2'd0;
      case (row_low)
         4'b0001: begin one_low = 1'b1; row_idx = 2'd0; end
         4'b0010: begin one_low = 1'b1; row_idx = 2'd1; end
         4'b0100: begin one_low = 1'b1; row_idx = 2'd2; end
         4'b1000: begin one_low = 1'b1; row_idx = 2'd3; end
         default: begin one_low = 1'b0; row_idx = 2'd0; end
      endcase
   end

   // FSM, dwell/debounce counters and key actions.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      match_d    = match_q;
      rel_d      = rel_q;
      cand_row_d = cand_row_q;
      digit_d    = digit_q;
      load_d     = 1'b0;
      en_d       = en_q;

      // Column changes only happen at the sample point, so the free-running
      // wrap also restarts the dwell on every column change.
      sample     = (dwell_q == DWELL_LAST);
      dwell_d    = sample ? '0 : dwell_q + DW'(1);
      cand_match = (row_low == (4'b0001 << cand_row_q));
      match_inc  = match_q + CW'(1);
      rel_inc    = rel_q + CW'(1);
      code       = key_decode(cand_row_q, col_q);

      case (state_q)
         ST_SCAN: begin
            if (sample) begin
               if (one_low) begin
                  cand_row_d = row_idx;
                  match_d    = '0;
                  rel_d      = '0;
                  state_d    = ST_DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (sample) begin
               if (cand_match) begin
                  if (match_inc == CNT_DONE) begin
                     if (code <= 4'd9) begin
                        digit_d = code;
                        load_d  = 1'b1;
                     end else if (code == KEY_STOP) begin
                        en_d = 1'b0;
                     end else if (code == KEY_RUN) begin
                        en_d = 1'b1;
                     end
                     match_d = '0;
                     rel_d   = '0;
                     state_d = ST_HELD;
                  end else begin
                     match_d = match_inc;
                  end
               end else begin
                  match_d = '0;
                  rel_d   = '0;
                  col_d   = col_q + 2'd1;
                  state_d = ST_SCAN;
               end
            end
         end
         ST_HELD: begin
            if (sample) begin
               if (row_low == 4'b0000) begin
                  if (rel_inc == CNT_DONE) begin
                     match_d = '0;
                     rel_d   = '0;
                     col_d   = col_q + 2'd1;
                     state_d = ST_SCAN;
                  end else begin
                     rel_d = rel_inc;
                  end
               end else begin
                  rel_d = '0;
               end
            end
         end
         default: begin
            match_d = '0;
            rel_d   = '0;
            state_d = ST_SCAN;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SCAN;
         col_q      <= 2'd0;
         dwell_q    <= '0;
         match_q    <= '0;
         rel_q      <= '0;
         cand_row_q <= 2'd0;
         digit_q    <= 4'd0;
         load_q     <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         dwell_q    <= dwell_d;
         match_q    <= match_d;
         rel_q      <= rel_d;
         cand_row_q <= cand_row_d;
         digit_q    <= digit_d;
         load_q     <= load_d;
         en_q       <= en_d;
      end
   end

   assign cols  = ~(4'b0001 << col_q);
   assign digit = digit_q;
   assign load  = load_q;
   assign en    = en_q;

endmodule
